// File: rtl/mux_scan_pkg.sv
// Shared types, default sizes and scan-order helpers for the mux scan serializer.
package mux_scan_pkg;

    localparam int DEFAULT_N_IN  = 8;
    localparam int DEFAULT_SEL_W = 3;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2
    } state_t;

    // First select index of a word for the given scan direction.
    function automatic int unsigned start_index(input bit msb_first, input int unsigned n_in);
        return msb_first ? n_in - 1 : 0;
    endfunction

    // Select index whose transfer ends the data portion of a word.
    function automatic int unsigned last_index(input bit msb_first, input int unsigned n_in);
        return msb_first ? 0 : n_in - 1;
    endfunction

endpackage

// File: rtl/mux_scan_serializer_counter.sv
// Up/down mux select counter with synchronous load, enable and terminal-count flag.
module scan_select_counter
    import mux_scan_pkg::*;
#(
    parameter int SEL_W = DEFAULT_SEL_W,
    parameter bit DOWN  = 1'b0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load,
    input  logic [SEL_W-1:0] load_value,
    input  logic             enable,
    output logic [SEL_W-1:0] count,
    output logic             terminal
);

    localparam logic [SEL_W-1:0] LAST = SEL_W'(last_index(DOWN, 2 ** SEL_W));

    assign terminal = (count == LAST);

    // Parks on the terminal index instead of wrapping; the next load restarts it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (enable && !terminal) begin
            count <= DOWN ? count - SEL_W'(1) : count + SEL_W'(1);
        end
    end

endmodule

// File: rtl/mux_scan_serializer.sv
// Holds a word on the 8:1 mux inputs, walks the select and streams z out as serial beats.
// Define MUX_SCAN_PARITY_EN to append an even-parity beat after every word.
module mux_scan_serializer
    import mux_scan_pkg::*;
#(
    parameter int N_IN      = DEFAULT_N_IN,
    parameter int SEL_W     = DEFAULT_SEL_W,
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load_valid,
    input  logic [N_IN-1:0]  load_data,
    output logic             load_ready,
    output logic [N_IN-1:0]  mux_input,
    output logic [SEL_W-1:0] select_bits,
    input  logic             z,
    output logic             ser_valid,
    output logic             ser_data,
    output logic             ser_last,
    input  logic             ser_ready
);

    localparam logic [1:0] ST_IDLE   = IDLE;
    localparam logic [1:0] ST_DATA   = DATA;
`ifdef MUX_SCAN_PARITY_EN
    localparam logic [1:0] ST_PARITY = PARITY;
`endif

    localparam logic [SEL_W-1:0] START_SEL = SEL_W'(start_index(MSB_FIRST, N_IN));

    logic [1:0] state;
    logic [1:0] state_next;
    logic       accept;
    logic       beat;
    logic       terminal;
`ifdef MUX_SCAN_PARITY_EN
    logic       parity;
`endif

    assign accept = load_valid && (state == ST_IDLE);
    assign beat   = ser_valid && ser_ready;

    scan_select_counter #(
        .SEL_W (SEL_W),
        .DOWN  (MSB_FIRST)
    ) select_counter (
        .clk        (clk),
        .reset_n    (reset_n),
        .load       (accept),
        .load_value (START_SEL),
        .enable     (beat && (state == ST_DATA)),
        .count      (select_bits),
        .terminal   (terminal)
    );

    // Outputs decode straight from state so an async reset clears them at once.
    always_comb begin
        load_ready = (state == ST_IDLE);
        ser_valid  = (state == ST_DATA);
        ser_data   = z;
        ser_last   = (state == ST_DATA) && terminal;
`ifdef MUX_SCAN_PARITY_EN
        ser_last   = 1'b0;
        if (state == ST_PARITY) begin
            ser_valid = 1'b1;
            ser_data  = parity;
            ser_last  = 1'b1;
        end
`endif
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    state_next = ST_DATA;
                end
            end
            ST_DATA: begin
                if (beat && terminal) begin
`ifdef MUX_SCAN_PARITY_EN
                    state_next = ST_PARITY;
`else
                    state_next = ST_IDLE;
`endif
                end
            end
`ifdef MUX_SCAN_PARITY_EN
            ST_PARITY: begin
                if (beat) begin
                    state_next = ST_IDLE;
                end
            end
`endif
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // The word only changes on an accept, keeping z stable through backpressure.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mux_input <= '0;
        end else if (accept) begin
            mux_input <= load_data;
        end
    end

`ifdef MUX_SCAN_PARITY_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            parity <= 1'b0;
        end else if (accept) begin
            parity <= ^load_data;
        end
    end
`endif

endmodule

// File: tb/tb_mux_scan_serializer.sv
// Scoreboard bench: lane 0 scans LSB first, lane 1 MSB first, each driving its own modelled 8:1 mux.
`timescale 1ns/1ps
module tb_mux_scan_serializer;

    localparam int NL = 2;

    typedef struct packed {
        logic       ln;
        logic       chk_sel;
        logic [2:0] sel;
        logic       data;
        logic       last;
    } beat_t;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       load_valid  [NL];
    logic [7:0] load_data   [NL];
    logic       load_ready  [NL];
    logic [7:0] mux_input   [NL];
    logic [2:0] select_bits [NL];
    logic       z           [NL];
    logic       ser_valid   [NL];
    logic       ser_data    [NL];
    logic       ser_last    [NL];
    logic       ser_ready   [NL];

    beat_t      exp_q[$];
    int         checks = 0;
    int         fails = 0;
    int         stall_cnt  [NL];
    bit         rand_ready [NL];
    bit         pend_idle  [NL];
    logic [7:0] held       [NL];

    always #5 clk = ~clk;

    for (genvar g = 0; g < NL; g++) begin : lane
        assign z[g] = mux_input[g][select_bits[g]];

        mux_scan_serializer #(
            .N_IN      (8),
            .SEL_W     (3),
            .MSB_FIRST (g == 1)
        ) dut (
            .clk         (clk),
            .reset_n     (reset_n),
            .load_valid  (load_valid[g]),
            .load_data   (load_data[g]),
            .load_ready  (load_ready[g]),
            .mux_input   (mux_input[g]),
            .select_bits (select_bits[g]),
            .z           (z[g]),
            .ser_valid   (ser_valid[g]),
            .ser_data    (ser_data[g]),
            .ser_last    (ser_last[g]),
            .ser_ready   (ser_ready[g])
        );
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            fails++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic timeoutFail(input string name);
        checks++;
        fails++;
        $display("[TB] FAIL %s: timed out at %0t", name, $time);
    endtask

    // Reference model: the word's bits in scan order, then the optional parity beat.
    task automatic pushWord(input int l, input logic [7:0] w);
        beat_t b;
        int    idx;
        for (int k = 0; k < 8; k++) begin
            idx       = (l == 1) ? 7 - k : k;
            b.ln      = l[0];
            b.chk_sel = 1'b1;
            b.sel     = idx[2:0];
            b.data    = w[idx];
`ifdef MUX_SCAN_PARITY_EN
            b.last    = 1'b0;
`else
            b.last    = (k == 7);
`endif
            exp_q.push_back(b);
        end
`ifdef MUX_SCAN_PARITY_EN
        b.ln      = l[0];
        b.chk_sel = 1'b0;
        b.sel     = 3'd0;
        b.data    = ^w;
        b.last    = 1'b1;
        exp_q.push_back(b);
`endif
    endtask

    task automatic applyStimulus(input int l, input logic [7:0] w);
        int n;
        n = 0;
        load_valid[l] = 1'b1;
        load_data[l]  = w;
        @(negedge clk);
        while (!load_ready[l] && n < 200) begin
            checkOutput("held_word_while_busy", mux_input[l], held[l]);
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            timeoutFail("load_accept");
            load_valid[l] = 1'b0;
        end else begin
            pushWord(l, w);
            @(posedge clk);
            #1;
            load_valid[l] = 1'b0;
            held[l] = w;
            checkOutput("first_beat_valid", ser_valid[l], 1);
            checkOutput("mux_input_capture", mux_input[l], w);
            checkOutput("load_ready_busy", load_ready[l], 0);
        end
    endtask

    task automatic waitIdle(input int l);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            #1;
            n++;
        end while ((exp_q.size() != 0 || !load_ready[l]) && n < 500);
        if (n >= 500) begin
            timeoutFail("word_drain");
            exp_q.delete();
        end
        @(posedge clk);
        #1;
    endtask

    task automatic waitSelect(input int l, input logic [2:0] sel);
        int n;
        n = 0;
        while (select_bits[l] !== sel && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 50) begin
            timeoutFail("wait_select");
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #2;
            for (int l = 0; l < NL; l++) begin
                if (stall_cnt[l] > 0) begin
                    ser_ready[l] = 1'b0;
                    stall_cnt[l]--;
                end else begin
                    ser_ready[l] = rand_ready[l] ? ($urandom_range(0, 2) != 0) : 1'b1;
                end
            end
        end
    end

    // Compares every presented beat with the queue head; pops only when it transfers.
    always @(negedge clk) begin
        beat_t b;
        if (!reset_n) begin
            for (int l = 0; l < NL; l++) begin
                pend_idle[l] = 1'b0;
            end
        end else begin
            for (int l = 0; l < NL; l++) begin
                if (pend_idle[l]) begin
                    checkOutput("load_ready_after_last", load_ready[l], 1);
                    checkOutput("ser_valid_after_last", ser_valid[l], 0);
                    pend_idle[l] = 1'b0;
                end
                if (ser_valid[l] === 1'b1) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        fails++;
                        $display("[TB] FAIL unexpected_beat: lane %0d got data %0b, expected no beat", l, ser_data[l]);
                    end else begin
                        b = exp_q[0];
                        checkOutput("beat_lane", l, b.ln);
                        if (b.chk_sel) begin
                            checkOutput("beat_select", select_bits[l], b.sel);
                        end
                        checkOutput("beat_data", ser_data[l], b.data);
                        checkOutput("beat_last", ser_last[l], b.last);
                        if (ser_ready[l]) begin
                            void'(exp_q.pop_front());
                            if (b.last) begin
                                pend_idle[l] = 1'b1;
                            end
                        end
                    end
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int         n;
        logic [7:0] w;
        reset_n = 1'b1;
        for (int l = 0; l < NL; l++) begin
            load_valid[l] = 1'b0;
            load_data[l]  = 8'h00;
            ser_ready[l]  = 1'b1;
            stall_cnt[l]  = 0;
            rand_ready[l] = 1'b0;
            held[l]       = 8'h00;
        end
        #1 reset_n = 1'b0;
        #3;
        for (int l = 0; l < NL; l++) begin
            checkOutput("reset_load_ready", load_ready[l], 1);
            checkOutput("reset_ser_valid", ser_valid[l], 0);
            checkOutput("reset_ser_last", ser_last[l], 0);
            checkOutput("reset_mux_input", mux_input[l], 0);
            checkOutput("reset_select", select_bits[l], 0);
        end
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        @(posedge clk);
        #1;

        $display("[TB] A5 LSB first, 8 back-to-back beats");
        applyStimulus(0, 8'hA5);
        n = 0;
        while (exp_q.size() != 0 && n < 50) begin
            @(negedge clk);
            #1;
            n++;
        end
`ifdef MUX_SCAN_PARITY_EN
        checkOutput("a5_beat_cycles", n, 9);
`else
        checkOutput("a5_beat_cycles", n, 8);
`endif
        waitIdle(0);

        $display("[TB] A5 MSB first");
        applyStimulus(1, 8'hA5);
        waitIdle(1);

        $display("[TB] 3C with 3-cycle stall on beat 4");
        applyStimulus(0, 8'h3C);
        waitSelect(0, 3'd3);
        stall_cnt[0] = 3;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checkOutput("stall_select", select_bits[0], 3);
            checkOutput("stall_data", ser_data[0], 1);
            checkOutput("stall_valid", ser_valid[0], 1);
            checkOutput("stall_ready_low", ser_ready[0], 0);
        end
        waitIdle(0);

        $display("[TB] FF offered while busy");
        applyStimulus(0, 8'hA5);
        applyStimulus(0, 8'hFF);
        waitIdle(0);

        $display("[TB] reset during beat 5 of 0F");
        applyStimulus(0, 8'h0F);
        waitSelect(0, 3'd4);
        #1 reset_n = 1'b0;
        #1;
        checkOutput("midreset_ser_valid", ser_valid[0], 0);
        checkOutput("midreset_ser_last", ser_last[0], 0);
        checkOutput("midreset_mux_input", mux_input[0], 0);
        checkOutput("midreset_select", select_bits[0], 0);
        checkOutput("midreset_load_ready", load_ready[0], 1);
        exp_q.delete();
        held[0] = 8'h00;
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        @(posedge clk);
        #1;
        applyStimulus(0, 8'h81);
        waitIdle(0);

        $display("[TB] 07 parity word on both lanes");
        applyStimulus(0, 8'h07);
        waitIdle(0);
        applyStimulus(1, 8'h07);
        waitIdle(1);

        $display("[TB] random words with random backpressure");
        for (int l = 0; l < NL; l++) begin
            rand_ready[l] = 1'b1;
            for (int k = 0; k < 12; k++) begin
                w = 8'($urandom);
                applyStimulus(l, w);
            end
            waitIdle(l);
            rand_ready[l] = 1'b0;
        end

        repeat (2) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
